// File: rtl/trace_pkg.sv
// trace_pkg: widths and record types shared by the trace collector.
// Lanes with tmask=0 are zeroed only when TRACE_ZERO_INACTIVE_EN is defined.
package trace_pkg;

   localparam int ARCH_LEN     = 32;
   localparam int NUM_WARPS    = 8;
   localparam int WARP_ID_BITS = $clog2(NUM_WARPS);
   localparam int NUM_LANES    = 16;
   localparam int REG_BITS     = 8;
   localparam int DATA_W       = NUM_LANES * ARCH_LEN;

   typedef logic [DATA_W-1:0] lanes_t;

   typedef struct packed {
      logic                enable;
      logic [REG_BITS-1:0] address;
      lanes_t              data;
   } trace_reg_t;

   typedef struct packed {
      logic [ARCH_LEN-1:0]     pc;
      logic [WARP_ID_BITS-1:0] warpId;
      logic [NUM_LANES-1:0]    tmask;
      trace_reg_t [2:0]        regs;
   } trace_rec_t;

   typedef struct packed {
      logic [ARCH_LEN-1:0]  pc;
      logic [NUM_LANES-1:0] tmask;
      trace_reg_t           rs1;
      trace_reg_t           rs2;
      logic [REG_BITS-1:0]  rd_address;
   } slot_t;

   function automatic trace_rec_t zero_inactive(input trace_rec_t r);
      trace_rec_t o;
      o = r;
      for (int k = 0; k < 3; k++) begin
         for (int g = 0; g < NUM_LANES; g++) begin
            if (!r.tmask[g]) begin
               o.regs[k].data[ARCH_LEN*g +: ARCH_LEN] = '0;
            end
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/trace_collector_if.sv
// trace_collector_if: issue, writeback and trace buses of the collector.
// slave = collector side, master = pipeline/tracer side.
interface trace_collector_if;
   import trace_pkg::*;

   logic                    issue_valid;
   logic                    issue_ready;
   logic [ARCH_LEN-1:0]     issue_pc;
   logic [WARP_ID_BITS-1:0] issue_warpId;
   logic [NUM_LANES-1:0]    issue_tmask;
   logic                    issue_rs1_enable;
   logic [REG_BITS-1:0]     issue_rs1_address;
   lanes_t                  issue_rs1_data;
   logic                    issue_rs2_enable;
   logic [REG_BITS-1:0]     issue_rs2_address;
   lanes_t                  issue_rs2_data;
   logic                    issue_rd_enable;
   logic [REG_BITS-1:0]     issue_rd_address;

   logic                    wb_valid;
   logic [WARP_ID_BITS-1:0] wb_warpId;
   logic [REG_BITS-1:0]     wb_address;
   lanes_t                  wb_data;

   logic                    trace_valid;
   logic [ARCH_LEN-1:0]     trace_pc;
   logic [WARP_ID_BITS-1:0] trace_warpId;
   logic [NUM_LANES-1:0]    trace_tmask;
   logic                    trace_regs_0_enable;
   logic [REG_BITS-1:0]     trace_regs_0_address;
   lanes_t                  trace_regs_0_data;
   logic                    trace_regs_1_enable;
   logic [REG_BITS-1:0]     trace_regs_1_address;
   lanes_t                  trace_regs_1_data;
   logic                    trace_regs_2_enable;
   logic [REG_BITS-1:0]     trace_regs_2_address;
   lanes_t                  trace_regs_2_data;

   modport slave (
      input  issue_valid, issue_pc, issue_warpId, issue_tmask,
      input  issue_rs1_enable, issue_rs1_address, issue_rs1_data,
      input  issue_rs2_enable, issue_rs2_address, issue_rs2_data,
      input  issue_rd_enable, issue_rd_address,
      input  wb_valid, wb_warpId, wb_address, wb_data,
      output issue_ready,
      output trace_valid, trace_pc, trace_warpId, trace_tmask,
      output trace_regs_0_enable, trace_regs_0_address, trace_regs_0_data,
      output trace_regs_1_enable, trace_regs_1_address, trace_regs_1_data,
      output trace_regs_2_enable, trace_regs_2_address, trace_regs_2_data
   );

   modport master (
      output issue_valid, issue_pc, issue_warpId, issue_tmask,
      output issue_rs1_enable, issue_rs1_address, issue_rs1_data,
      output issue_rs2_enable, issue_rs2_address, issue_rs2_data,
      output issue_rd_enable, issue_rd_address,
      output wb_valid, wb_warpId, wb_address, wb_data,
      input  issue_ready,
      input  trace_valid, trace_pc, trace_warpId, trace_tmask,
      input  trace_regs_0_enable, trace_regs_0_address, trace_regs_0_data,
      input  trace_regs_1_enable, trace_regs_1_address, trace_regs_1_data,
      input  trace_regs_2_enable, trace_regs_2_address, trace_regs_2_data
   );

endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: dual-push (push0 lands before push1), pop-every-cycle record FIFO.
// Head reads as zero while empty so the trace bus idles at 0.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type rec_t = trace_rec_t,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push0_i,
   input  rec_t        data0_i,
   input  logic        push1_i,
   input  rec_t        data1_i,
   output logic        valid_o,
   output rec_t        head_o,
   output logic [PW:0] count_o
);

   rec_t        mem_q [DEPTH];
   logic [PW:0] wr_q, wr_d;
   logic [PW:0] rd_q, rd_d;
   logic [PW:0] wr_nx;
   logic        empty;
   logic        full;
   rec_t        first;

   assign empty   = wr_q == rd_q;
   assign full    = (wr_q[PW] != rd_q[PW]) &&
                    (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign count_o = {full, wr_q[PW-1:0] - rd_q[PW-1:0]};
   assign valid_o = !empty;
   assign head_o  = empty ? '0 : mem_q[rd_q[PW-1:0]];
   assign first   = push0_i ? data0_i : data1_i;
   assign wr_nx   = wr_q + (PW+1)'(1);

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push0_i) wr_d = wr_d + (PW+1)'(1);
      if (push1_i) wr_d = wr_d + (PW+1)'(1);
      if (!empty)  rd_d = rd_q + (PW+1)'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push0_i || push1_i) mem_q[wr_q[PW-1:0]] <= first;
      if (push0_i && push1_i) mem_q[wr_nx[PW-1:0]] <= data1_i;
   end

endmodule

// File: rtl/trace_collector.sv
// trace_collector: pairs per-warp issue with its writeback, one record per retire.
// Optional TRACE_ZERO_INACTIVE_EN zeroes inactive-lane data at FIFO push.
module trace_collector
   import trace_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   trace_collector_if.slave bus,
   output logic             err
);

   localparam int          PW        = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] ISSUE_MAX = (PW+1)'(FIFO_DEPTH - 2);

   logic [NUM_WARPS-1:0] busy_q, busy_d;
   slot_t                slot_q [NUM_WARPS];
   slot_t                wb_slot;
   slot_t                new_slot;
   logic                 err_q, err_d;
   logic                 wb_hit;
   logic                 issue_fire;
   logic                 issue_push;
   logic [PW:0]          count;
   trace_rec_t           wb_rec, is_rec;
   trace_rec_t           wb_push, is_push;
   trace_rec_t           head;
   logic                 head_valid;

   assign wb_slot = slot_q[bus.wb_warpId];
   assign wb_hit  = bus.wb_valid && busy_q[bus.wb_warpId] &&
                    (wb_slot.rd_address == bus.wb_address);

   // Two free entries cover an issue push colliding with a writeback push.
   assign bus.issue_ready = !reset && !busy_q[bus.issue_warpId] &&
                            (count <= ISSUE_MAX);
   assign issue_fire = bus.issue_valid && bus.issue_ready;
   assign issue_push = issue_fire && !bus.issue_rd_enable;

   always_comb begin
      new_slot             = '0;
      new_slot.pc          = bus.issue_pc;
      new_slot.tmask       = bus.issue_tmask;
      new_slot.rs1.enable  = bus.issue_rs1_enable;
      new_slot.rs1.address = bus.issue_rs1_address;
      new_slot.rs1.data    = bus.issue_rs1_data;
      new_slot.rs2.enable  = bus.issue_rs2_enable;
      new_slot.rs2.address = bus.issue_rs2_address;
      new_slot.rs2.data    = bus.issue_rs2_data;
      new_slot.rd_address  = bus.issue_rd_address;
   end

   always_comb begin
      wb_rec                 = '0;
      wb_rec.pc              = wb_slot.pc;
      wb_rec.warpId          = bus.wb_warpId;
      wb_rec.tmask           = wb_slot.tmask;
      wb_rec.regs[0]         = wb_slot.rs1;
      wb_rec.regs[1]         = wb_slot.rs2;
      wb_rec.regs[2].enable  = 1'b1;
      wb_rec.regs[2].address = bus.wb_address;
      wb_rec.regs[2].data    = bus.wb_data;
      is_rec                 = '0;
      is_rec.pc              = new_slot.pc;
      is_rec.warpId          = bus.issue_warpId;
      is_rec.tmask           = new_slot.tmask;
      is_rec.regs[0]         = new_slot.rs1;
      is_rec.regs[1]         = new_slot.rs2;
   end

`ifdef TRACE_ZERO_INACTIVE_EN
   assign wb_push = zero_inactive(wb_rec);
   assign is_push = zero_inactive(is_rec);
`else
   assign wb_push = wb_rec;
   assign is_push = is_rec;
`endif

   always_comb begin
      busy_d = busy_q;
      err_d  = err_q;
      if (issue_fire && bus.issue_rd_enable) busy_d[bus.issue_warpId] = 1'b1;
      if (wb_hit)                            busy_d[bus.wb_warpId]    = 1'b0;
      if (bus.wb_valid && !wb_hit)           err_d                    = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   always_ff @(posedge clock) begin
      if (issue_fire && bus.issue_rd_enable) begin
         slot_q[bus.issue_warpId] <= new_slot;
      end
   end

   trace_fifo #(
      .DEPTH (FIFO_DEPTH),
      .rec_t (trace_rec_t)
   ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push0_i (wb_hit),
      .data0_i (wb_push),
      .push1_i (issue_push),
      .data1_i (is_push),
      .valid_o (head_valid),
      .head_o  (head),
      .count_o (count)
   );

   assign err                      = err_q;
   assign bus.trace_valid          = head_valid;
   assign bus.trace_pc             = head.pc;
   assign bus.trace_warpId         = head.warpId;
   assign bus.trace_tmask          = head.tmask;
   assign bus.trace_regs_0_enable  = head.regs[0].enable;
   assign bus.trace_regs_0_address = head.regs[0].address;
   assign bus.trace_regs_0_data    = head.regs[0].data;
   assign bus.trace_regs_1_enable  = head.regs[1].enable;
   assign bus.trace_regs_1_address = head.regs[1].address;
   assign bus.trace_regs_1_data    = head.regs[1].data;
   assign bus.trace_regs_2_enable  = head.regs[2].enable;
   assign bus.trace_regs_2_address = head.regs[2].address;
   assign bus.trace_regs_2_data    = head.regs[2].data;

endmodule
